// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM encoding, FIFO sizing and byte width.
// Imported by the TX FIFO now and intended for the RX path later.
package uart_pkg;

    localparam int UART_TX_FIFO_DEPTH = 16;
    localparam int UART_BYTE_W        = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_REQ   = 2'd2,
        ST_DRAIN = 2'd3
    } tx_state_t;

endpackage

// File: rtl/uart_fifo_ram.sv
// DEPTH x DW register array: synchronous write, asynchronous (combinational) read.
// Latency: write visible on read port after the write edge; read is zero-cycle.
// No flow control here; the owner guarantees writes only target free slots.
module uart_fifo_ram
    import uart_pkg::*;
#(
    parameter int DEPTH = UART_TX_FIFO_DEPTH,
    parameter int AW    = $clog2(DEPTH),
    parameter int DW    = UART_BYTE_W
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte TX FIFO feeding the UART transmitter through a tx_start/clear_req handshake.
// Latency: push to tx_start is 2 cycles when empty and idle; pushes are dropped (sticky overflow) when full.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = UART_TX_FIFO_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,
    input  logic                   wr_valid,
    input  logic [UART_BYTE_W-1:0] wr_data,
    output logic                   wr_ready,
    input  logic                   flush,
    input  logic                   clr_ovf,
    output logic [UART_BYTE_W-1:0] tx_data,
    output logic                   tx_start,
    input  logic                   clear_req,
    input  logic                   tx_busy,
    output logic [AW:0]            level,
    output logic                   empty,
    output logic                   full,
    output logic                   overflow,
    output logic                   irq_drained
);

    localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    tx_state_t              state;
    tx_state_t              state_nxt;
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic [UART_BYTE_W-1:0] head_byte;
    logic                   push;
    logic                   drop;
    logic                   pop;
    logic                   load;

    assign empty    = (level == '0);
    assign full     = (level == LVL_FULL);
    assign wr_ready = !full;

    // full is judged on the pre-pop level, so a push alongside a pop at full is still dropped.
    assign push = wr_valid && !full && !flush;
    assign drop = wr_valid &&  full && !flush;
    assign pop  = (state == ST_REQ) && clear_req && !flush;

    uart_fifo_ram #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (UART_BYTE_W)
    ) u_ram (
        .clk   (wb_clk_i),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (wr_data),
        .raddr (rd_ptr),
        .rdata (head_byte)
    );

    always_comb begin
        state_nxt = state;
        tx_start  = 1'b0;
        load      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!empty && !tx_busy) begin
                    state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                load      = 1'b1;
                state_nxt = ST_REQ;
            end
            ST_REQ: begin
                tx_start = 1'b1;
                if (clear_req) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!tx_busy) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        // A frame already handed to the transmitter keeps going; we only stop asking.
        if (flush) begin
            state_nxt = ST_IDLE;
            load      = 1'b0;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   level <= level + LVL_ONE;
                2'b01:   level <= level - LVL_ONE;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            tx_data <= '0;
        end else if (load) begin
            tx_data <= head_byte;
        end
    end

    // Set beats clear when both land in the same cycle.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            irq_drained <= 1'b0;
        end else begin
            irq_drained <= pop && !push && (level == LVL_ONE);
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: reset, single byte, full/overflow ordering,
// pointer wrap with simultaneous push/pop, flush during a request, overflow clear.
module tb_uart_tx_fifo;

    logic       wb_clk_i = 1'b0;
    logic       wb_rst_i = 1'b1;
    logic       wr_valid = 1'b0;
    logic [7:0] wr_data  = 8'h00;
    logic       wr_ready;
    logic       flush    = 1'b0;
    logic       clr_ovf  = 1'b0;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       clear_req = 1'b0;
    logic       tx_busy   = 1'b0;
    logic [4:0] level;
    logic       empty;
    logic       full;
    logic       overflow;
    logic       irq_drained;

    int n_cmp = 0;
    int n_bad = 0;

    uart_tx_fifo #(.DEPTH(16), .AW(4)) dut (
        .wb_clk_i    (wb_clk_i),
        .wb_rst_i    (wb_rst_i),
        .wr_valid    (wr_valid),
        .wr_data     (wr_data),
        .wr_ready    (wr_ready),
        .flush       (flush),
        .clr_ovf     (clr_ovf),
        .tx_data     (tx_data),
        .tx_start    (tx_start),
        .clear_req   (clear_req),
        .tx_busy     (tx_busy),
        .level       (level),
        .empty       (empty),
        .full        (full),
        .overflow    (overflow),
        .irq_drained (irq_drained)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        wr_valid = 1'b1;
        wr_data  = b;
        step();
        wr_valid = 1'b0;
    endtask

    task automatic wait_req(input string tag);
        int n;
        n = 0;
        while (!tx_start && n < 60) begin
            step();
            n++;
        end
        if (!tx_start) chk({tag, "_req_timeout"}, 32'(tx_start), 1);
    endtask

    task automatic serve(input logic [7:0] exp, input string tag);
        wait_req(tag);
        chk({tag, "_data"}, 32'(tx_data), 32'(exp));
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        chk({tag, "_start_low"}, 32'(tx_start), 0);
    endtask

    initial begin
        // Reset
        step();
        step();
        chk("rst_tx_start", 32'(tx_start), 0);
        chk("rst_tx_data", 32'(tx_data), 0);
        chk("rst_level", 32'(level), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_wr_ready", 32'(wr_ready), 1);
        chk("rst_overflow", 32'(overflow), 0);
        chk("rst_irq", 32'(irq_drained), 0);
        wb_rst_i = 1'b0;
        step();

        // Single byte: request 2 edges after the push edge
        push(8'hA5);
        chk("one_level", 32'(level), 1);
        chk("one_empty", 32'(empty), 0);
        chk("one_start_n", 32'(tx_start), 0);
        step();
        chk("one_start_n1", 32'(tx_start), 0);
        step();
        chk("one_start_n2", 32'(tx_start), 1);
        chk("one_data", 32'(tx_data), 32'h0A5);
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        chk("one_ack_start", 32'(tx_start), 0);
        chk("one_ack_level", 32'(level), 0);
        chk("one_ack_irq", 32'(irq_drained), 1);
        step();
        chk("one_irq_gone", 32'(irq_drained), 0);
        chk("one_data_hold", 32'(tx_data), 32'h0A5);

        // Full, overflow, in-order drain
        tx_busy = 1'b1;
        for (int i = 0; i < 16; i++) push(8'(i));
        chk("full_flag", 32'(full), 1);
        chk("full_level", 32'(level), 16);
        chk("full_wr_ready", 32'(wr_ready), 0);
        chk("full_start", 32'(tx_start), 0);
        push(8'hFF);
        chk("ovf_set", 32'(overflow), 1);
        chk("ovf_level", 32'(level), 16);
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        chk("ovf_clr_alone", 32'(overflow), 0);
        tx_busy = 1'b0;
        for (int i = 0; i < 16; i++) serve(8'(i), $sformatf("order%0d", i));
        chk("order_level", 32'(level), 0);
        chk("order_empty", 32'(empty), 1);

        // Wrap: fill 10, drain 10, fill 16
        tx_busy = 1'b1;
        for (int i = 0; i < 10; i++) push(8'(8'h10 + i));
        tx_busy = 1'b0;
        for (int i = 0; i < 10; i++) serve(8'(8'h10 + i), $sformatf("wrapa%0d", i));
        tx_busy = 1'b1;
        for (int i = 0; i < 16; i++) push(8'(8'h20 + i));
        chk("wrap_full", 32'(full), 1);
        wr_valid = 1'b1;
        wr_data  = 8'hEE;
        clr_ovf  = 1'b1;
        step();
        wr_valid = 1'b0;
        clr_ovf  = 1'b0;
        chk("ovf_set_beats_clr", 32'(overflow), 1);
        chk("ovf_drop_level", 32'(level), 16);
        tx_busy = 1'b0;
        for (int i = 0; i < 11; i++) serve(8'(8'h20 + i), $sformatf("wrapb%0d", i));
        chk("wrap_level5", 32'(level), 5);
        wait_req("pushpop");
        chk("pushpop_data", 32'(tx_data), 32'h02B);
        clear_req = 1'b1;
        wr_valid  = 1'b1;
        wr_data   = 8'h99;
        step();
        clear_req = 1'b0;
        wr_valid  = 1'b0;
        chk("pushpop_level", 32'(level), 5);
        chk("pushpop_irq", 32'(irq_drained), 0);
        for (int i = 0; i < 4; i++) serve(8'(8'h2C + i), $sformatf("wrapc%0d", i));
        serve(8'h99, "wrap_last");
        chk("wrap_last_irq", 32'(irq_drained), 1);
        chk("wrap_end_level", 32'(level), 0);

        // Flush during REQ with a coincident push
        tx_busy = 1'b1;
        push(8'h31);
        push(8'h32);
        push(8'h33);
        tx_busy = 1'b0;
        wait_req("flush");
        chk("flush_pre_data", 32'(tx_data), 32'h031);
        flush    = 1'b1;
        wr_valid = 1'b1;
        wr_data  = 8'h77;
        step();
        flush    = 1'b0;
        wr_valid = 1'b0;
        chk("flush_start", 32'(tx_start), 0);
        chk("flush_level", 32'(level), 0);
        chk("flush_empty", 32'(empty), 1);
        chk("flush_ovf", 32'(overflow), 1);
        chk("flush_irq", 32'(irq_drained), 0);
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 12; i++) begin
                if (tx_start || irq_drained) seen++;
                step();
            end
            chk("flush_quiet", 32'(seen), 0);
        end

        // Clear overflow after everything
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        chk("ovf_final_clr", 32'(overflow), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
